if_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register for the merge-sort RISC-V pipeline with hazard control.
- Holds the PC, drives the instruction-memory read port, and registers the fetched instruction and PC.
- Its registered instruction feeds the decode control unit. It obeys stall requests from the hazard unit and redirect (flush) requests from branch/jump resolution in EX.
- Keeps saturating stall and flush counters for debug.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/pipe_reg_if_id.sv | 35 +++
 rtl/if_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the merge-sort RISC-V pipeline.
//   XLEN      : datapath width
//   NOP_INST  : bubble instruction. Opcode 0 decodes as the control unit's
//               default nop, with register write and memory write disabled.
//   OP_*      : major opcode values, bits [6:0]
//   if_id_t   : IF/ID pipeline-register contents
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/pipe_reg_if_id.sv
// Generic pipeline register. It is used for IF/ID and can be reused for
// later pipeline stages by changing W and RESET_VAL.
//   clk, reset : rising-edge clock and synchronous active-high reset
//   enable     : load d when high. Low holds the register (stall).
//   flush      : load bubble. Flush has priority over enable.
//   bubble     : value loaded on flush
//   d          : value loaded on enable
//   q          : registered contents
// Priority order: reset > flush > enable > hold.
module pipe_reg_if_id
  import riscv_pkg::*;
#(
  parameter int             W         = $bits(if_id_t),
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         flush,
  input  logic [W-1:0] bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (flush) begin
      q <= bubble;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// This module is the instruction-fetch stage together with the IF/ID
// pipeline register.
//   clk, reset      : rising-edge clock and synchronous active-high reset
//   stall           : hazard unit request. Holds the PC and IF/ID.
//   redirect        : taken branch, JAL or JALR resolved in EX
//   redirect_pc     : redirect target. Bits [1:0] are dropped, and a
//                     nonzero value sets misalign_err.
//   imem_addr       : fetch address, equal to the PC (combinational)
//   imem_rdata      : instruction at imem_addr, returned in the same cycle
//   if_id_*         : registered instruction, its PC, PC+4 and valid flag
//   misalign_err    : sticky flag. Cleared only by reset.
//   stall_cnt       : number of cycles a stall took effect (saturating)
//   flush_cnt       : number of redirect cycles (saturating)
// Control contract: inputs are sampled on each rising edge with priority
// redirect > stall > advance. A redirect always wins, because the
// instruction that redirects is older than the one the stall protects. In
// a redirect or stall cycle, imem_rdata is ignored, so X on it cannot reach
// IF/ID.
module if_stage
  import riscv_pkg::XLEN;
  import riscv_pkg::if_id_t;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  if_id_inst,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [XLEN-1:0]  if_id_pc4,
  output logic             if_id_valid,
  output logic             misalign_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int RW = $bits(if_id_t);

  localparam if_id_t IF_ID_RESET = '{inst: NOP_INST, pc: '0, pc4: '0, valid: 1'b0};

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_next;
  logic            stall_taken;

  if_id_t if_id_d;
  if_id_t if_id_q;
  if_id_t if_id_bubble;

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc;
  assign stall_taken = stall & ~redirect;

  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (!stall) begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // A flush turns the instruction into a bubble but keeps the old PC
  // fields. Only inst and valid carry meaning for a bubble.
  assign if_id_d      = '{inst: imem_rdata, pc: pc, pc4: pc_plus4, valid: 1'b1};
  assign if_id_bubble = '{inst: NOP_INST, pc: if_id_q.pc, pc4: if_id_q.pc4, valid: 1'b0};

  pipe_reg_if_id #(
    .W         (RW),
    .RESET_VAL (IF_ID_RESET)
  ) u_if_id (
    .clk    (clk),
    .reset  (reset),
    .enable (~stall),
    .flush  (redirect),
    .bubble (if_id_bubble),
    .d      (if_id_d),
    .q      (if_id_q)
  );

  assign if_id_inst  = if_id_q.inst;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      if (redirect && (redirect_pc[1:0] != 2'b00)) begin
        misalign_err <= 1'b1;
      end
      if (stall_taken && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (redirect && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule
